// File: rtl/sram_port_arbiter_pkg.sv
// Shared types and constants for the IF/EX SRAM port arbiter.
package sram_port_arbiter_pkg;

  localparam int SRAM_DW        = 32;
  localparam int STARVE_MAX_DEF = 3;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_INST = 2'd1,
    RESP_DATA = 2'd2
  } resp_e;

endpackage

// File: rtl/sram_port_arbiter_rdata_hold.sv
// Per-requester read data path: live SRAM data on rvalid, else last value.
module arb_rdata_hold
  import sram_port_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               rvalid,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic [SRAM_DW-1:0] rdata
);

  logic [SRAM_DW-1:0] hold_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (rvalid) begin
      hold_q <= sram_rdata;
    end
  end

  assign rdata = rvalid ? sram_rdata : hold_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter: data priority, inst wins after STARVE_MAX refusals.
// Optional perf counters via ARB_PERF_CNT_EN.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int ADDR_W     = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inst_req,
  input  logic [ADDR_W-1:0]  inst_addr,
  output logic               inst_gnt,
  output logic               inst_rvalid,
  output logic [SRAM_DW-1:0] inst_rdata,
  input  logic               data_req,
  input  logic [3:0]         data_wen,
  input  logic [ADDR_W-1:0]  data_addr,
  input  logic [SRAM_DW-1:0] data_wdata,
  output logic               data_gnt,
  output logic               data_rvalid,
  output logic [SRAM_DW-1:0] data_rdata,
  output logic               sram_en,
  output logic [3:0]         sram_wen,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [SRAM_DW-1:0] sram_wdata,
  input  logic [SRAM_DW-1:0] sram_rdata,
  output logic               stallreq_from_arb
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        conflict_cnt,
  output logic [31:0]        starve_win_cnt
`endif
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  resp_e      resp_q;
  resp_e      resp_d;
  logic       starve_hit;
  logic       win_inst;

  assign starve_hit = (starve_cnt == STARVE_LIM);
  assign win_inst   = inst_req & (~data_req | starve_hit);
  assign inst_gnt   = win_inst;
  assign data_gnt   = data_req & ~win_inst;

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (inst_gnt) begin
      sram_en   = 1'b1;
      sram_addr = inst_addr;
    end else if (data_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = data_wen;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end
  end

  always_comb begin
    resp_d = RESP_NONE;
    if (inst_gnt) begin
      resp_d = RESP_INST;
    end else if (data_gnt && data_wen == 4'd0) begin
      resp_d = RESP_DATA;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_q     <= RESP_NONE;
      starve_cnt <= '0;
    end else begin
      resp_q <= resp_d;
      if (inst_req && !inst_gnt) begin
        if (!starve_hit) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  assign inst_rvalid = (resp_q == RESP_INST);
  assign data_rvalid = (resp_q == RESP_DATA);

  assign stallreq_from_arb = (inst_req & ~inst_gnt) |
                             (data_req & ~data_gnt);

  arb_rdata_hold u_inst_hold (
    .clk        (clk),
    .rst        (rst),
    .rvalid     (inst_rvalid),
    .sram_rdata (sram_rdata),
    .rdata      (inst_rdata)
  );

  arb_rdata_hold u_data_hold (
    .clk        (clk),
    .rst        (rst),
    .rvalid     (data_rvalid),
    .sram_rdata (sram_rdata),
    .rdata      (data_rdata)
  );

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt   <= '0;
      starve_win_cnt <= '0;
    end else if (inst_req && data_req) begin
      if (conflict_cnt != '1) begin
        conflict_cnt <= conflict_cnt + 32'd1;
      end
      if (inst_gnt && starve_win_cnt != '1) begin
        starve_win_cnt <= starve_win_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
